stopwatch_ctrl: RTL and testbench

Run/pause/clear sequencer for a four-digit mm:ss stopwatch built from limited-increment digit stages. It owns the one-second time base and the start/stop/clear state machine. It ripples a one-cycle tick through a chain of four digit counters using saturate-to-zero-with-carry semantics. The counters are digit 0 (limit 9), digit 1 (limit 5), digit 2 (limit 9) and digit 3 (limit 5). Outputs feed the seven-segment display driver on the BASYS3 top level.

---
 rtl/stopwatch_ctrl.sv | 142 ++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear sequencer for an mm:ss stopwatch: one-second prescaler, FSM and BCD digit chain.
// Optional lap/freeze display hold is compiled in with `define STOPWATCH_LAP_EN.

module stopwatch_digit #(
  parameter logic [3:0] LIMIT = 4'd9
) (
  input  logic [3:0] i_v,
  input  logic       i_ci,
  output logic [3:0] o_nxt,
  output logic       o_co
);
  // Out-of-range values also roll to zero and carry, but only when a carry arrives.
  always_comb begin
    o_nxt = i_v;
    o_co  = 1'b0;
    if (i_ci) begin
      if (i_v >= LIMIT) begin
        o_nxt = 4'd0;
        o_co  = 1'b1;
      end else begin
        o_nxt = i_v + 4'd1;
      end
    end
  end
endmodule

module stopwatch_ctrl #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start_stop,
  input  logic        i_clear,
`ifdef STOPWATCH_LAP_EN
  input  logic        i_lap,
  output logic [15:0] o_disp,
`endif
  output logic [15:0] o_time,
  output logic        o_running,
  output logic        o_wrap
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [3:0][3:0] LIMITS = {4'd5, 4'd9, 4'd5, 4'd9};

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [PW-1:0]        r_presc;
  logic [3:0][3:0]      r_time;
  logic [3:0][3:0]      w_time_inc;
  logic [3:0][3:0]      w_time_nxt;
  logic [4:0]           w_carry;
  logic                 w_tick;
  logic                 r_running;
  logic                 r_wrap;

  assign w_tick     = (r_state == RUN) && (r_presc == PRESC_MAX);
  assign w_carry[0] = w_tick;

  for (genvar k = 0; k < 4; k++) begin : g_dig
    stopwatch_digit #(.LIMIT(LIMITS[k])) u_dig (
      .i_v   (r_time[k]),
      .i_ci  (w_carry[k]),
      .o_nxt (w_time_inc[k]),
      .o_co  (w_carry[k+1])
    );
  end

  // clear outranks start_stop, so a simultaneous pair lands in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    if (i_clear) begin
      w_state_nxt = IDLE;
    end else if (i_start_stop) begin
      case (r_state)
        IDLE:    w_state_nxt = RUN;
        RUN:     w_state_nxt = PAUSE;
        PAUSE:   w_state_nxt = RUN;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    w_time_nxt = r_time;
    if (i_clear)     w_time_nxt = '0;
    else if (w_tick) w_time_nxt = w_time_inc;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_presc   <= '0;
      r_time    <= '0;
      r_running <= 1'b0;
      r_wrap    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_running <= (w_state_nxt == RUN);
      r_time    <= w_time_nxt;
      if (i_clear) begin
        r_presc <= '0;
        r_wrap  <= 1'b0;
      end else begin
        r_wrap <= w_carry[4];
        if (r_state == RUN)
          r_presc <= w_tick ? '0 : r_presc + PW'(1);
      end
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic        r_freeze;
  logic        w_freeze_nxt;
  logic [15:0] r_disp;

  always_comb begin
    w_freeze_nxt = r_freeze;
    if (i_clear)                        w_freeze_nxt = 1'b0;
    else if (i_lap && r_state != IDLE)  w_freeze_nxt = ~r_freeze;
  end

  // Track the next time value so disp equals time whenever unfrozen.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_freeze <= 1'b0;
      r_disp   <= '0;
    end else begin
      r_freeze <= w_freeze_nxt;
      if (!w_freeze_nxt) r_disp <= w_time_nxt;
    end
  end

  assign o_disp = r_disp;
`endif

  assign o_time    = r_time;
  assign o_running = r_running;
  assign o_wrap    = r_wrap;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV = 4; checks timing, carry, wrap, clear and reset.
module tb_stopwatch_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_stop = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] tim;
  logic        running;
  logic        wrap;
`ifdef STOPWATCH_LAP_EN
  logic        lap = 1'b0;
  logic [15:0] disp;
`endif
  int vectors = 0;
  int errs = 0;

  stopwatch_ctrl #(.TICK_DIV(4)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_start_stop (start_stop),
    .i_clear      (clear),
`ifdef STOPWATCH_LAP_EN
    .i_lap        (lap),
    .o_disp       (disp),
`endif
    .o_time       (tim),
    .o_running    (running),
    .o_wrap       (wrap)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1;
    cyc(1);
    start_stop = 1'b0;
  endtask

  task automatic pulse_clr();
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
  endtask

  initial begin
    // reset
    cyc(2);
    reset = 1'b0;
    chk("rst_time", tim, 16'h0000);
    chk("rst_running", {15'd0, running}, 16'd0);
    chk("rst_wrap", {15'd0, wrap}, 16'd0);
`ifdef STOPWATCH_LAP_EN
    chk("rst_disp", disp, 16'h0000);
`endif

    // run: E0 samples start_stop
    pulse_ss();
    chk("run_running", {15'd0, running}, 16'd1);
    chk("run_time_e0", tim, 16'h0000);
    cyc(3);
    chk("run_time_e3", tim, 16'h0000);
    cyc(1);
    chk("run_time_e4", tim, 16'h0001);
    cyc(4);
    chk("run_time_e8", tim, 16'h0002);

    pulse_clr();
    chk("clr_time", tim, 16'h0000);
    chk("clr_running", {15'd0, running}, 16'd0);

    // pause at E0+6 with prescaler 2, resume two cycles short of a tick
    pulse_ss();
    cyc(5);
    pulse_ss();
    chk("pause_running", {15'd0, running}, 16'd0);
    chk("pause_time", tim, 16'h0001);
    cyc(10);
    chk("pause_hold", tim, 16'h0001);
    pulse_ss();
    chk("resume_running", {15'd0, running}, 16'd1);
    cyc(1);
    chk("resume_e1p1", tim, 16'h0001);
    cyc(1);
    chk("resume_e1p2", tim, 16'h0002);
    cyc(4);
    chk("pre_clrprio", tim, 16'h0003);

    // clear with start_stop in the same cycle
    clear = 1'b1;
    start_stop = 1'b1;
    cyc(1);
    clear = 1'b0;
    start_stop = 1'b0;
    chk("clrprio_time", tim, 16'h0000);
    chk("clrprio_running", {15'd0, running}, 16'd0);
    cyc(8);
    chk("clrprio_hold", tim, 16'h0000);

    // carry chain and wrap
    pulse_ss();
    cyc(2396);
    chk("carry_0959", tim, 16'h0959);
    cyc(4);
    chk("carry_1000", tim, 16'h1000);
    cyc(11996);
    chk("wrap_5959", tim, 16'h5959);
    chk("wrap_pre", {15'd0, wrap}, 16'd0);
    cyc(3);
    chk("wrap_hold", tim, 16'h5959);
    cyc(1);
    chk("wrap_time", tim, 16'h0000);
    chk("wrap_pulse", {15'd0, wrap}, 16'd1);
    cyc(1);
    chk("wrap_one", {15'd0, wrap}, 16'd0);
    chk("wrap_after", tim, 16'h0000);

    // reset on the tick that would carry 09 -> 10
    pulse_clr();
    pulse_ss();
    cyc(36);
    chk("midrst_pre", tim, 16'h0009);
    cyc(3);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk("midrst_time", tim, 16'h0000);
    chk("midrst_wrap", {15'd0, wrap}, 16'd0);
    chk("midrst_running", {15'd0, running}, 16'd0);
    cyc(8);
    chk("midrst_idle", tim, 16'h0000);

`ifdef STOPWATCH_LAP_EN
    pulse_ss();
    cyc(8);
    lap = 1'b1;
    cyc(1);
    lap = 1'b0;
    chk("lap_disp", disp, 16'h0002);
    cyc(7);
    chk("lap_time4", tim, 16'h0004);
    chk("lap_frozen", disp, 16'h0002);
    lap = 1'b1;
    cyc(1);
    lap = 1'b0;
    chk("lap_unfreeze", disp, 16'h0004);
    pulse_clr();
    lap = 1'b1;
    cyc(1);
    lap = 1'b0;
    pulse_ss();
    cyc(4);
    chk("lap_idle_ignored", disp, 16'h0001);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
